// File: rtl/game_ctrl.sv
// game_ctrl: button-driven game FSM with scrolling pipe, collision and scoring.
// Optional macro RANDOM_GAP_EN: randomise the pipe gap on reload from an 8-bit LFSR.
module game_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              flap_btn,
    input  logic signed [9:0] bird_y,
    output logic              flap_pulse,
    output logic              bird_rst,
    output logic [1:0]        state,
    output logic [9:0]        pipe_x,
    output logic [9:0]        gap_y,
    output logic [7:0]        score
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic signed [10:0] BIRD_X = 11'sd160;
    localparam logic signed [10:0] BIRD_R = 11'sd8;
    localparam logic signed [10:0] PIPE_W = 11'sd40;
    localparam logic signed [10:0] GAP_H  = 11'sd120;
    localparam logic signed [10:0] SCROLL = 11'sd2;
    localparam logic [9:0]         SCREEN_W = 10'd640;
    localparam logic [9:0]         GAP_RST  = 10'd180;

    state_t st;
    logic   sync1;
    logic   sync2;
    logic   sync3;
    logic   btn_evt;
    logic   scored;

    logic signed [10:0] px_s;
    logic signed [10:0] by_s;
    logic signed [10:0] gy_s;
    logic               hit_x;
    logic               miss_gap;
    logic               collide;
    logic               wrap;
    logic               pass;
    logic [9:0]         new_gap;

    assign state = st;

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= flap_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign btn_evt = sync2 & ~sync3;

`ifdef RANDOM_GAP_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign new_gap = 10'd64 + {2'b00, lfsr};
`else
    assign new_gap = GAP_RST;
`endif

    assign px_s     = {1'b0, pipe_x};
    assign by_s     = {bird_y[9], bird_y};
    assign gy_s     = {1'b0, gap_y};
    assign hit_x    = (px_s <= BIRD_X + BIRD_R) &&
                      (px_s + PIPE_W >= BIRD_X - BIRD_R);
    assign miss_gap = (by_s < gy_s) || (by_s > gy_s + GAP_H);
    assign collide  = (by_s <= 11'sd0) || (hit_x && miss_gap);
    assign wrap     = px_s < SCROLL;
    assign pass     = !scored && (px_s + PIPE_W < BIRD_X - BIRD_R);

    // Game FSM with registered outputs; collision beats scoring, reload beats scoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            bird_rst   <= 1'b1;
            flap_pulse <= 1'b0;
            pipe_x     <= SCREEN_W;
            gap_y      <= GAP_RST;
            score      <= 8'd0;
            scored     <= 1'b0;
        end else begin
            flap_pulse <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (btn_evt) begin
                        st       <= PLAY;
                        bird_rst <= 1'b0;
                        score    <= 8'd0;
                        pipe_x   <= SCREEN_W;
                        scored   <= 1'b0;
                    end
                end
                PLAY: begin
                    flap_pulse <= btn_evt;
                    if (tick) begin
                        if (collide) begin
                            st <= OVER;
                        end else if (wrap) begin
                            pipe_x <= SCREEN_W;
                            gap_y  <= new_gap;
                            scored <= 1'b0;
                        end else begin
                            pipe_x <= pipe_x - 10'd2;
                            if (pass) begin
                                scored <= 1'b1;
                                if (score != 8'd255) begin
                                    score <= score + 8'd1;
                                end
                            end
                        end
                    end
                end
                OVER: begin
                    if (btn_evt) begin
                        st       <= IDLE;
                        bird_rst <= 1'b1;
                    end
                end
                default: begin
                    st       <= IDLE;
                    bird_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
